// File: rtl/key_blink_driver.sv
// key_blink_driver
// Turns single-cycle key-press events into fixed-length LED blink bursts.
// Events arriving while a burst plays are counted in pend_cnt and replayed
// one burst per event, in order, with one IDLE clock between bursts.
//
// Ports:
//   clk       board clock, the only clock
//   rst_n     asynchronous active-low reset
//   evt_in    key-press event, one-clock pulse synchronous to clk
//   led_out   LED drive, active-low (0 = lit), registered
//   busy      high while a burst is playing, registered
//   pend_cnt  events accepted but not yet started, saturating
//   overflow  one-clock pulse when an event is dropped at saturation
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no burst; starts one when pend_cnt > 0
// ON    | LED lit, timer counts 0 .. ON_CYCLES-1
// OFF   | LED dark, timer counts 0 .. OFF_CYCLES-1
module key_blink_driver #(
  parameter int ON_CYCLES  = 12_500_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int BLINKS     = 3,
  parameter int PEND_W     = 3,
  parameter int CNT_W      = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              evt_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int IDX_W = (BLINKS > 1) ? $clog2(BLINKS) : 1;

  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BLINKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      led_q   <= 1'b1;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // A burst starts only from the counter, never straight from evt_in, so
  // every event costs exactly one pending slot and yields exactly one burst.
  assign start = (state_q == IDLE) && (pend_q != '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    led_d   = led_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        led_d   = 1'b1;
        busy_d  = 1'b0;
        if (start) begin
          state_d = ON;
          led_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ON: begin
        if (timer_q == ON_LAST) begin
          state_d = OFF;
          timer_d = '0;
          led_d   = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
          end else begin
            state_d = ON;
            idx_d   = idx_q + IDX_W'(1);
            led_d   = 1'b0;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        idx_d   = '0;
        led_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Start and event in the same clock cancel out: one slot consumed, one added.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (evt_in && !start) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (start && !evt_in) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pend_cnt = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_key_blink_driver.sv
// Bench for key_blink_driver with ON=4, OFF=3, BLINKS=2, PEND_W=2.
// Every accepted event pushes one expected burst; a monitor pops one entry at
// each burst start and checks the burst waveform. Directed checks compare
// against absolute edge numbers counted from reset release.
module tb_key_blink_driver;

  localparam int ON    = 4;
  localparam int OFF   = 3;
  localparam int NBL   = 2;
  localparam int PW    = 2;
  localparam int BURST = NBL * (ON + OFF);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          evt_in;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pend_cnt;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;

  int sb_q[$];
  int bursts_seen = 0;
  int ovf_seen = 0;
  bit in_burst = 0;

  key_blink_driver #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .BLINKS    (NBL),
    .PEND_W    (PW),
    .CNT_W     (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .evt_in  (evt_in),
    .led_out (led_out),
    .busy    (busy),
    .pend_cnt(pend_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc - t0, obs, exp);
    end
  endtask

  // Scoreboard consumer: one popped entry per burst start, then a cycle-by-cycle
  // comparison against the ideal lit/dark pattern and the single IDLE gap.
  initial begin
    int pos;
    bit prev_busy;
    pos = 0;
    prev_busy = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_burst = 0;
        pos = 0;
        prev_busy = 0;
      end else begin
        if (overflow) ovf_seen++;
        if (!in_burst && busy && !prev_busy) begin
          check_eq("burst_expected", (sb_q.size() != 0), 1);
          if (sb_q.size() != 0) void'(sb_q.pop_front());
          bursts_seen++;
          in_burst = 1;
          pos = 0;
        end
        if (in_burst) begin
          if (pos < BURST) begin
            check_eq("burst_led", led_out, ((pos % (ON + OFF)) < ON) ? 0 : 1);
            check_eq("burst_busy", busy, 1);
          end else begin
            check_eq("burst_end_busy", busy, 0);
            check_eq("burst_end_led", led_out, 1);
            in_burst = 0;
          end
          pos++;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    evt_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    bursts_seen = 0;
    ovf_seen = 0;
  endtask

  // Returns at the negedge following edge k (counted from reset release).
  task automatic wait_edge(input int k);
    while (cyc < t0 + k) @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy || in_burst || pend_cnt != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_in_time", (n < limit), 1);
    check_eq("drain_sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    evt_in = 1'b0;

    // Reset held with evt_in toggling: outputs pinned to reset values.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("rst_led", led_out, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_pend", pend_cnt, 0);
      check_eq("rst_ovf", overflow, 0);
      evt_in = ~evt_in;
    end

    // Single event at edge 10.
    do_reset();
    wait_edge(9);
    evt_in = 1'b1;
    sb_q.push_back(1);
    for (int k = 10; k <= 26; k++) begin
      wait_edge(k);
      evt_in = 1'b0;
      check_eq("single_led", led_out,
               ((k >= 11 && k <= 14) || (k >= 18 && k <= 21)) ? 0 : 1);
      check_eq("single_busy", busy, (k >= 11 && k <= 24) ? 1 : 0);
      check_eq("single_pend", pend_cnt, (k == 10) ? 1 : 0);
    end
    drain(100);
    check_eq("single_bursts", bursts_seen, 1);

    // Queued events at edges 10, 12, 13.
    do_reset();
    wait_edge(9);
    evt_in = 1'b1;
    sb_q.push_back(1);
    wait_edge(10);
    evt_in = 1'b0;
    check_eq("queue_pend_e10", pend_cnt, 1);
    wait_edge(11);
    evt_in = 1'b1;
    sb_q.push_back(2);
    check_eq("queue_pend_e11", pend_cnt, 0);
    check_eq("queue_busy_e11", busy, 1);
    wait_edge(12);
    sb_q.push_back(3);
    check_eq("queue_pend_e12", pend_cnt, 1);
    wait_edge(13);
    evt_in = 1'b0;
    check_eq("queue_pend_e13", pend_cnt, 2);
    for (int k = 14; k <= 58; k++) begin
      wait_edge(k);
      check_eq("queue_busy", busy,
               ((k <= 24) || (k >= 26 && k <= 39) || (k >= 41 && k <= 54)) ? 1 : 0);
      check_eq("queue_pend", pend_cnt, (k < 26) ? 2 : (k < 41) ? 1 : 0);
    end
    drain(100);
    check_eq("queue_bursts", bursts_seen, 3);

    // Overflow: one burst running, then four more events; the fourth is dropped.
    do_reset();
    wait_edge(1);
    evt_in = 1'b1;
    sb_q.push_back(1);
    wait_edge(2);
    evt_in = 1'b0;
    check_eq("ovf_pend_e2", pend_cnt, 1);
    wait_edge(3);
    check_eq("ovf_busy_e3", busy, 1);
    check_eq("ovf_pend_e3", pend_cnt, 0);
    for (int j = 0; j < 4; j++) begin
      wait_edge(4 + 2 * j);
      evt_in = 1'b1;
      if (j < 3) sb_q.push_back(2 + j);
      wait_edge(5 + 2 * j);
      evt_in = 1'b0;
      check_eq("ovf_pend", pend_cnt, (j < 3) ? j + 1 : 3);
      check_eq("ovf_flag", overflow, (j == 3) ? 1 : 0);
    end
    wait_edge(12);
    check_eq("ovf_flag_clear", overflow, 0);
    check_eq("ovf_pend_hold", pend_cnt, 3);
    drain(200);
    check_eq("ovf_pulses", ovf_seen, 1);
    check_eq("ovf_bursts", bursts_seen, 4);

    // Event coincides with the start clock: count holds at 1.
    do_reset();
    wait_edge(9);
    evt_in = 1'b1;
    sb_q.push_back(1);
    wait_edge(10);
    sb_q.push_back(2);
    check_eq("simul_pend_e10", pend_cnt, 1);
    check_eq("simul_busy_e10", busy, 0);
    wait_edge(11);
    evt_in = 1'b0;
    check_eq("simul_pend_e11", pend_cnt, 1);
    check_eq("simul_busy_e11", busy, 1);
    wait_edge(25);
    check_eq("simul_busy_e25", busy, 0);
    check_eq("simul_pend_e25", pend_cnt, 1);
    wait_edge(26);
    check_eq("simul_busy_e26", busy, 1);
    check_eq("simul_pend_e26", pend_cnt, 0);
    drain(100);
    check_eq("simul_bursts", bursts_seen, 2);

    // Reset in the second ON phase with two events pending.
    do_reset();
    wait_edge(9);
    evt_in = 1'b1;
    sb_q.push_back(1);
    wait_edge(10);
    evt_in = 1'b0;
    wait_edge(11);
    evt_in = 1'b1;
    sb_q.push_back(2);
    wait_edge(12);
    sb_q.push_back(3);
    wait_edge(13);
    evt_in = 1'b0;
    wait_edge(19);
    check_eq("midrst_led_pre", led_out, 0);
    check_eq("midrst_busy_pre", busy, 1);
    check_eq("midrst_pend_pre", pend_cnt, 2);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_eq("midrst_led", led_out, 1);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_pend", pend_cnt, 0);
    check_eq("midrst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bursts_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check_eq("midrst_idle_busy", busy, 0);
      check_eq("midrst_idle_led", led_out, 1);
    end
    check_eq("midrst_bursts", bursts_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
